// File: rtl/minrv32_mem_pkg.sv
// minrv32_mem_pkg: shared FSM encoding and access-size masks for the memory responder
package minrv32_mem_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;
    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;
    function automatic logic mask_ok(input logic [3:0] m);
        return m == 4'b0000 || m == MASK_B || m == MASK_H || m == MASK_W;
    endfunction
    function automatic logic [31:0] lane_mask(input logic [3:0] m);
        return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction
endpackage

// File: rtl/minrv32_bytemask_ram.sv
// minrv32_bytemask_ram: 32-bit word RAM with per-byte write enables and registered read
module minrv32_bytemask_ram #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [31:0] mem [0:(1<<AW)-1];
    // Write enabled byte lanes and register the old word on every access
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++)
                if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            rdata <= mem[addr];
        end
    end
endmodule

// File: rtl/minrv32_mem_responder.sv
// minrv32_mem_responder: wait-stated single-port RAM responder for the minrv32 memory bus
module minrv32_mem_responder
    import minrv32_mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wmask,
    input  logic [3:0]  mem_rmask,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        mem_err,
    output logic [7:0]  err_count
);
    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic [31:0] addr_q, wdata_q, cur_addr, cur_wdata, ram_q;
    logic [3:0]  wmask_q, rmask_q, cur_wmask, cur_rmask, acc_mask, we;
    logic        err_q, req_err, go_resp, unused_instr;
    assign unused_instr = mem_instr;
    // With zero wait states the RAM access happens on the capture edge, so use live inputs in IDLE
    assign cur_addr  = (state == ST_IDLE) ? mem_addr  : addr_q;
    assign cur_wdata = (state == ST_IDLE) ? mem_wdata : wdata_q;
    assign cur_wmask = (state == ST_IDLE) ? mem_wmask : wmask_q;
    assign cur_rmask = (state == ST_IDLE) ? mem_rmask : rmask_q;
    assign acc_mask  = (|cur_wmask) ? cur_wmask : cur_rmask;
    assign req_err   = ((|cur_wmask) && (|cur_rmask)) || !mask_ok(cur_wmask) || !mask_ok(cur_rmask)
                    || (acc_mask == 4'b0000) || (acc_mask == MASK_H && cur_addr[0])
                    || (acc_mask == MASK_W && cur_addr[1:0] != 2'b00)
                    || ((cur_addr >> (ADDR_WIDTH + 2)) != 32'd0);
    assign go_resp   = state_n == ST_RESP;
    assign we        = (go_resp && !req_err) ? 4'(cur_wmask << cur_addr[1:0]) : 4'b0000;
    // Next state: count down in WAIT, abort if the requester withdraws
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            ST_IDLE: if (mem_valid) begin
                state_n = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
                cnt_n   = 4'(WAIT_STATES);
            end
            ST_WAIT: begin
                state_n = !mem_valid ? ST_IDLE : (cnt == 4'd1) ? ST_RESP : ST_WAIT;
                cnt_n   = (!mem_valid || cnt == 4'd1) ? 4'd0 : cnt - 4'd1;
            end
            default: state_n = ST_IDLE;
        endcase
    end
    // State, request capture, error flag and saturating error counter
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            cnt       <= 4'd0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wmask_q   <= '0;
            rmask_q   <= '0;
            err_q     <= 1'b0;
            err_count <= 8'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (state == ST_IDLE && mem_valid) begin
                addr_q  <= mem_addr;
                wdata_q <= mem_wdata;
                wmask_q <= mem_wmask;
                rmask_q <= mem_rmask;
            end
            if (go_resp) err_q <= req_err;
            if (go_resp && req_err && err_count != 8'hFF) err_count <= err_count + 8'd1;
        end
    end
    minrv32_bytemask_ram #(.AW(ADDR_WIDTH)) u_ram (
        .clk   (clk),
        .en    (go_resp),
        .we    (we),
        .addr  (cur_addr[ADDR_WIDTH+1:2]),
        .wdata (32'(cur_wdata << {cur_addr[1:0], 3'b000})),
        .rdata (ram_q)
    );
    assign mem_ready = state == ST_RESP;
    assign mem_err   = mem_ready && err_q;
    assign mem_rdata = (mem_ready && !err_q) ? ((ram_q >> {addr_q[1:0], 3'b000}) & lane_mask(rmask_q)) : 32'd0;
endmodule

// File: tb/tb_minrv32_mem_responder.sv
// tb_minrv32_mem_responder: directed and randomized checks against a byte-array memory model
module tb_minrv32_mem_responder;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        mem_valid = 1'b0, mem_instr = 1'b0;
    logic [31:0] mem_addr = '0, mem_wdata = '0;
    logic [3:0]  mem_wmask = '0, mem_rmask = '0;
    logic        mem_ready, mem_err;
    logic [31:0] mem_rdata;
    logic [7:0]  err_count;
    int          tests = 0, fails = 0;
    logic [7:0]  mdl [0:4095];
    int          mdl_errs = 0;

    always #5 clk = ~clk;

    minrv32_mem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(1)) dut (
        .clk(clk), .resetn(resetn), .mem_valid(mem_valid), .mem_instr(mem_instr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rmask(mem_rmask),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_err(mem_err), .err_count(err_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int msize(input logic [3:0] m);
        return m == 4'b0001 ? 1 : m == 4'b0011 ? 2 : m == 4'b1111 ? 4 : 0;
    endfunction

    // Reference: decide legality from access size/alignment, then move bytes in the array
    task automatic model(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] wm,
                         input logic [3:0] rm, output logic er, output logic [31:0] rd);
        int sz;
        bit legal_w, legal_r;
        legal_w = (wm == 0) || msize(wm) != 0;
        legal_r = (rm == 0) || msize(rm) != 0;
        sz = (wm != 0) ? msize(wm) : msize(rm);
        er = (wm != 0 && rm != 0) || !legal_w || !legal_r || (wm == 0 && rm == 0)
             || a >= 32'd4096 || (sz != 0 && (a % sz) != 0);
        rd = 0;
        if (!er) begin
            for (int i = 0; i < sz; i++) begin
                if (wm != 0) mdl[a + i] = wd[8*i +: 8];
                else rd[8*i +: 8] = mdl[a + i];
            end
        end
        if (er && mdl_errs < 255) mdl_errs++;
    endtask

    task automatic do_req(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] wm,
                          input logic [3:0] rm, output bit got, output int lat,
                          output logic [31:0] rd, output logic er);
        @(negedge clk);
        mem_addr = a; mem_wdata = wd; mem_wmask = wm; mem_rmask = rm;
        mem_instr = 1'($urandom); mem_valid = 1'b1;
        got = 0; lat = 0; rd = 0; er = 0;
        while (!got && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (mem_ready) begin got = 1; rd = mem_rdata; er = mem_err; end
        end
        mem_valid = 1'b0;
    endtask

    task automatic xact(input string tag, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] wm, input logic [3:0] rm);
        bit got; int lat; logic [31:0] rd, erd; logic er, eer;
        model(a, wd, wm, rm, eer, erd);
        do_req(a, wd, wm, rm, got, lat, rd, er);
        chk({tag, ".ready"}, 32'(got), 32'd1);
        chk({tag, ".latency"}, lat, 32'd2);
        chk({tag, ".rdata"}, rd, erd);
        chk({tag, ".err"}, 32'(er), 32'(eer));
        chk({tag, ".err_count"}, 32'(err_count), mdl_errs);
        @(posedge clk); #1;
        chk({tag, ".ready_drop"}, {mem_ready, mem_err, mem_rdata != 0}, 0);
    endtask

    initial begin
        logic [31:0] a, wd;
        logic [3:0] wm, rm;
        int k;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.outputs", {mem_ready, mem_err, err_count}, 0);
        chk("reset.rdata", mem_rdata, 0);
        @(negedge clk) resetn = 1'b1;

        for (int i = 0; i < 64; i++) xact("init", 32'(4 * i), $urandom, 4'b1111, 4'b0000);

        xact("sw_10", 32'h10, 32'hDEADBEEF, 4'b1111, 4'b0000);
        xact("lw_10", 32'h10, 0, 4'b0000, 4'b1111);
        xact("sb_13", 32'h13, 32'h000000AA, 4'b0001, 4'b0000);
        xact("lw_10b", 32'h10, 0, 4'b0000, 4'b1111);
        chk("lw_10b.value", {mdl[19], mdl[18], mdl[17], mdl[16]}, 32'hAAADBEEF);
        xact("lbu_13", 32'h13, 0, 4'b0000, 4'b0001);
        xact("lh_12", 32'h12, 0, 4'b0000, 4'b0011);
        xact("lw_12_err", 32'h12, 0, 4'b0000, 4'b1111);
        chk("err_count_1", err_count, 1);
        xact("lh_11_err", 32'h11, 0, 4'b0000, 4'b0011);
        chk("err_count_2", err_count, 2);
        xact("lw_10_unch", 32'h10, 0, 4'b0000, 4'b1111);
        xact("oob_1000", 32'h1000, 0, 4'b0000, 4'b1111);

        // Abort: withdraw mem_valid during WAIT; no response and no write
        @(negedge clk);
        mem_addr = 32'h20; mem_wdata = 32'h12345678; mem_wmask = 4'b1111; mem_rmask = 0; mem_valid = 1'b1;
        @(posedge clk); #1;
        mem_valid = 1'b0;
        k = 0;
        repeat (5) begin @(posedge clk); #1; k += int'(mem_ready); end
        chk("abort.no_ready", k, 0);
        xact("abort.lw_20", 32'h20, 0, 4'b0000, 4'b1111);

        // Reset pulse while in WAIT clears outputs asynchronously and drops the request
        @(negedge clk);
        mem_addr = 32'h24; mem_wdata = 32'h55555555; mem_wmask = 4'b1111; mem_rmask = 0; mem_valid = 1'b1;
        @(posedge clk); #2;
        resetn = 1'b0;
        #1;
        chk("rst_wait.async", {mem_ready, mem_err, err_count}, 0);
        mem_valid = 1'b0;
        mdl_errs = 0;
        k = 0;
        repeat (3) begin @(posedge clk); #1; k += int'(mem_ready); end
        @(negedge clk) resetn = 1'b1;
        repeat (2) begin @(posedge clk); #1; k += int'(mem_ready); end
        chk("rst_wait.no_ready", k, 0);
        xact("rst_wait.lw_24", 32'h24, 0, 4'b0000, 4'b1111);

        for (int n = 0; n < 300; n++) begin
            k = int'($urandom_range(0, 9));
            a = $urandom_range(0, 255);
            wd = $urandom;
            wm = 0; rm = 0;
            case (k)
                0: rm = 4'b0001;
                1: rm = 4'b0011;
                2: rm = 4'b1111;
                3: wm = 4'b0001;
                4: wm = 4'b0011;
                5: wm = 4'b1111;
                6: begin wm = 4'b0001; rm = 4'b0001; end
                7: ;
                8: rm = 4'($urandom_range(4, 14));
                default: begin a = 32'h1000 + $urandom_range(0, 255) * 4; rm = 4'b1111; end
            endcase
            if (k == 1 || k == 4) a = a & ~32'h1 | 32'($urandom_range(0, 1));
            xact("rand", a, wd, wm, rm);
        end

        for (int n = 0; n < 260; n++) xact("sat", 32'h2000, 0, 4'b0000, 4'b1111);
        chk("sat.err_count", err_count, 255);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
